// File: rtl/modadd_ctrl.sv
// Sequencer for (a +/- b) mod m on 1027-bit operands. It runs one or two
// transactions on an external multi-cycle adder and then picks the reduced result.
module modadd_ctrl (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          subtract,
    input  logic [1026:0] in_a,
    input  logic [1026:0] in_b,
    input  logic [1026:0] in_m,
    output logic [1026:0] result,
    output logic          done,
    output logic          busy,
    output logic          add_start,
    output logic          add_subtract,
    output logic [1026:0] add_in_a,
    output logic [1026:0] add_in_b,
    input  logic [1027:0] add_result,
    input  logic          add_done
);

    typedef enum logic [2:0] {
        IDLE,
        OP1_ISSUE,
        OP1_WAIT,
        OP2_ISSUE,
        OP2_WAIT,
        FINISH
    } state_t;

    state_t        state, state_nxt;
    logic [1026:0] m_q;
    logic          sub_q;
    logic          op1_final;

    // A subtraction without a borrow is already reduced and needs no second pass.
    assign op1_final = sub_q && !add_result[1027];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case statement,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        add_start = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:      if (start) state_nxt = OP1_ISSUE;
            OP1_ISSUE: begin
                add_start = 1'b1;
                state_nxt = OP1_WAIT;
            end
            OP1_WAIT:  if (add_done) state_nxt = op1_final ? FINISH : OP2_ISSUE;
            OP2_ISSUE: begin
                add_start = 1'b1;
                state_nxt = OP2_WAIT;
            end
            OP2_WAIT:  if (add_done) state_nxt = FINISH;
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // The adder operand registers change only on the edges that enter an issue
    // state. They therefore stay stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            add_in_a     <= '0;
            add_in_b     <= '0;
            add_subtract <= 1'b0;
            m_q          <= '0;
            sub_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    add_in_a     <= in_a;
                    add_in_b     <= in_b;
                    add_subtract <= subtract;
                    m_q          <= in_m;
                    sub_q        <= subtract;
                end
                OP1_WAIT: if (add_done) begin
                    if (op1_final) begin
                        result <= add_result[1026:0];
                    end else begin
                        add_in_a     <= add_result[1026:0];
                        add_in_b     <= m_q;
                        add_subtract <= ~sub_q;
                    end
                end
                OP2_WAIT: if (add_done) begin
                    // In the addition path add_in_a still holds t. A borrow from t - m
                    // means t was already below m.
                    if (!sub_q && add_result[1027]) result <= add_in_a;
                    else                            result <= add_result[1026:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modadd_ctrl.sv
// Scoreboard bench for modadd_ctrl. A behavioural adder with latency 3 is attached,
// directed vectors are applied, and a monitor checks every done pulse.
module tb_modadd_ctrl;

    logic          clk = 1'b0;
    logic          reset, start, subtract;
    logic [1026:0] in_a, in_b, in_m;
    logic [1026:0] result;
    logic          done, busy, add_start, add_subtract;
    logic [1026:0] add_in_a, add_in_b;
    logic [1027:0] add_result;
    logic          add_done;

    modadd_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .subtract     (subtract),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int n_add_start  = 0;

    typedef struct {
        logic [1026:0] res;
        int            lat;
        int            s;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [1027:0] act, input logic [1027:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h expected 0x%h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    // Behavioural adder: add_done arrives 3 cycles after the add_start cycle.
    logic [1:0]    cnt = 2'd0;
    logic          model_done = 1'b0;
    logic          inject_done = 1'b0;
    logic [1027:0] model_res = '0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        model_done <= 1'b0;
        if (add_start) begin
            cnt       <= 2'd2;
            model_res <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                      : ({1'b0, add_in_a} + {1'b0, add_in_b});
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) model_done <= 1'b1;
        end
    end

    assign add_done   = model_done | inject_done;
    assign add_result = model_res;

    always @(negedge clk) if (add_start === 1'b1) n_add_start++;

    // Monitor: each done pulse is compared against the oldest pending expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1028'(done), 1028'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {1'b0, result}, {1'b0, e.res});
                check("latency", 1028'(cyc - e.s), 1028'(e.lat));
            end
        end
    end

    task automatic issue(input logic sub, input logic [1026:0] a, input logic [1026:0] b,
                         input logic [1026:0] m, input logic [1026:0] exp_res,
                         input int exp_lat, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
        if (push) begin
            e.res = exp_res; e.lat = exp_lat; e.s = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check({"timeout ", name}, 1028'(seen), 1028'(1));
    endtask

    task automatic run_op(input string name, input logic sub, input logic [1026:0] a,
                          input logic [1026:0] b, input logic [1026:0] m,
                          input logic [1026:0] exp_res, input int exp_lat, input int exp_starts);
        int n0;
        n0 = n_add_start;
        issue(sub, a, b, m, exp_res, exp_lat, 1'b1);
        wait_done(name);
        @(negedge clk);
        check({"add_starts ", name}, 1028'(n_add_start - n0), 1028'(exp_starts));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " result"},       {1'b0, result},   '0);
        check({tag, " done"},         1028'(done),      '0);
        check({tag, " busy"},         1028'(busy),      '0);
        check({tag, " add_start"},    1028'(add_start), '0);
        check({tag, " add_in_a"},     {1'b0, add_in_a}, '0);
        check({tag, " add_in_b"},     {1'b0, add_in_b}, '0);
        check({tag, " add_subtract"}, 1028'(add_subtract), '0);
    endtask

    logic [1026:0] m_big;
    int            n0;

    initial begin
        m_big = {1'b0, {1026{1'b1}}};
        reset = 1'b1; start = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        run_op("add 5+4 m7",  1'b0, 1027'd5, 1027'd4, 1027'd7, 1027'd2, 9, 2);
        run_op("add 1+2 m7",  1'b0, 1027'd1, 1027'd2, 1027'd7, 1027'd3, 9, 2);
        run_op("sub 2-5 m7",  1'b1, 1027'd2, 1027'd5, 1027'd7, 1027'd4, 9, 2);
        run_op("sub 5-2 m7",  1'b1, 1027'd5, 1027'd2, 1027'd7, 1027'd3, 5, 1);
        run_op("add big",     1'b0, m_big - 1, m_big - 1, m_big, m_big - 2, 9, 2);
        run_op("sub big",     1'b1, '0, m_big - 1, m_big, 1027'd1, 9, 2);

        // A start raised while busy, carrying different operands, must be ignored.
        n0 = n_add_start;
        issue(1'b0, 1027'd5, 1027'd4, 1027'd7, 1027'd2, 9, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; subtract = 1'b1; in_a = 1027'd1; in_b = 1027'd2; in_m = 1027'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy start");
        repeat (4) @(negedge clk);
        check("busy ignored add_starts", 1028'(n_add_start - n0), 1028'(2));
        check("busy ignored result", {1'b0, result}, 1028'(2));

        // Reset during OP1_WAIT. The pending adder completion then arrives in IDLE.
        issue(1'b0, 1027'd3, 1027'd3, 1027'd7, '0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid reset");
        reset = 1'b0;
        n0 = n_add_start;
        @(negedge clk);
        check("stale done busy", 1028'(busy), '0);
        check("stale done add_start", 1028'(add_start), '0);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        @(negedge clk);
        check("late done busy", 1028'(busy), '0);
        check("late done done", 1028'(done), '0);
        check("late done add_starts", 1028'(n_add_start - n0), '0);

        run_op("after reset add 6+6 m7", 1'b0, 1027'd6, 1027'd6, 1027'd7, 1027'd5, 9, 2);
        run_op("after reset sub 3-3 m7", 1'b1, 1027'd3, 1027'd3, 1027'd7, 1027'd0, 5, 1);

        repeat (3) @(negedge clk);
        check("scoreboard empty", 1028'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modadd_ctrl.md
# modadd_ctrl

Sequencing front-end that computes modular addition or subtraction, (a ± b) mod m, on 1027-bit operands. It drives an external multi-cycle mpadder-style unit as the initiator of that unit's start/done handshake: it issues one or two add/subtract transactions and selects the reduced result. It sits between the Montgomery datapath control and a shared mpadder instance.

## Interface
Parameters:
- none; widths are fixed at 1027 operand bits and a 1028-bit adder result.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- subtract  in  1  0 = (a+b) mod m, 1 = (a−b) mod m; latched with start
- in_a  in  1027  operand a; precondition a < m
- in_b  in  1027  operand b; precondition b < m
- in_m  in  1027  modulus m; precondition 0 < m < 2^1026
- result  out  1027  reduced result; holds its value until the next accepted start
- done  out  1  one-cycle pulse when result is valid
- busy  out  1  high from the cycle after start is accepted until done
- add_start  out  1  one-cycle request pulse to the adder
- add_subtract  out  1  adder mode, 1 = in_a − in_b
- add_in_a  out  1027  adder operand A
- add_in_b  out  1027  adder operand B
- add_result  in  1028  adder output; two's-complement in subtract mode, bit 1027 set iff A < B
- add_done  in  1  one-cycle completion pulse from the adder

## Operation
- States: IDLE, OP1_ISSUE, OP1_WAIT, OP2_ISSUE, OP2_WAIT, FINISH.
- IDLE + start:
  - Latch in_a, in_b, in_m and subtract into internal registers.
  - Go to OP1_ISSUE.
  - start in any other state is ignored.
- Addition:
  - OP1 is A=a, B=b, add.
  - On add_done, capture t = add_result[1026:0]. t < 2^1027 is guaranteed by the preconditions.
  - OP2 is A=t, B=m, subtract.
  - On add_done: if add_result[1027]=1, result = t; else result = add_result[1026:0].
  - Addition always takes 2 adder transactions.
- Subtraction:
  - OP1 is A=a, B=b, subtract.
  - On add_done, capture d = add_result[1026:0].
  - If add_result[1027]=0: result = d, go straight to FINISH. This is 1 transaction.
  - Else OP2 is A=d, B=m, add. Result = add_result[1026:0], the low bits of the sum, which equal a−b+m.
- Adder-side outputs:
  - add_in_a, add_in_b and add_subtract are held stable from the add_start cycle through the add_done cycle.
  - Outside a transaction they keep their last value.
- add_done is acted on only in OP1_WAIT or OP2_WAIT. In any other state it is ignored, including a stale pulse after reset.
- FINISH: done=1 for one cycle, result updated, then return to IDLE.
- Reset, including mid-operation:
  - Next state is IDLE.
  - add_start=0, done=0, busy=0, result=0, add_in_a=0, add_in_b=0, add_subtract=0.
- Operands violating the preconditions give an unspecified result. The FSM still terminates.

## Timing
- start high at edge k is accepted → OP1_ISSUE during cycle k+1: add_start=1, busy=1.
- OP1_ISSUE → OP1_WAIT unconditionally. add_start is exactly one cycle wide.
- add_done high in cycle j of OP1_WAIT:
  - For a 2-transaction operation, cycle j+1 is OP2_ISSUE with add_start=1.
  - Otherwise cycle j+1 is FINISH.
- add_done high in cycle j of OP2_WAIT → FINISH in cycle j+1.
- Total latency, start edge to done, with adder latency L (add_start cycle to add_done cycle):
  - 1 transaction: L+2 cycles.
  - 2 transactions: 2L+3 cycles.
- add_done coinciding with the add_start cycle (L=0) is not supported.
- busy falls in the cycle after done. A new start is accepted at the edge ending the done cycle +1, i.e. the first IDLE cycle.
- Back-to-back starts: minimum issue interval is latency+1.

## Test plan
Bench pairs the block with a behavioural adder of latency L=3 and counts add_start pulses.
- m=7, a=5, b=4, add → result=2. Two transactions; done 9 cycles after start.
- m=7, a=1, b=2, add → result=3. Second op borrows; two transactions.
- m=7, a=2, b=5, subtract → result=4. Two transactions (OP1 borrow, then +m).
- m=7, a=5, b=2, subtract → result=3. Exactly one add_start; done 5 cycles after start.
- m=2^1026−1, a=b=m−1, add → result=m−2. Then subtract with a=0, b=m−1 → result=1.
- Busy and reset behaviour:
  - A second start during busy is ignored: add_start count and result are unchanged.
  - reset asserted during OP1_WAIT → next cycle all outputs are 0.
  - A late add_done while in IDLE is ignored.
  - A new start then completes correctly.
